// File: rtl/receive_ordered_set.sv
// receive_ordered_set: receive-side ordered-set FSM of the 1000BASE-X PCS.
// Classifies decoded code groups, drives GMII RX and keeps packet counters.
module receive_ordered_set #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 gtx_clk,
    input  logic                 mr_main_reset,
    input  logic                 sync_status,
    input  logic                 rx_even,
    input  logic [7:0]           rx_octet,
    input  logic                 rx_is_k,
    input  logic                 rx_invalid,
    output logic                 rx_dv,
    output logic                 rx_er,
    output logic [7:0]           rxd,
    output logic                 receiving,
    output logic [CNT_WIDTH-1:0] pkt_ok_cnt,
    output logic [CNT_WIDTH-1:0] pkt_err_cnt
);

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K_S   = 8'hFB;
    localparam logic [7:0] K_T   = 8'hFD;
    localparam logic [7:0] K_R   = 8'hF7;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    localparam int LF_B   = 0;
    localparam int IDLE_B = 1;
    localparam int RX_B   = 2;
    localparam int EPDT_B = 3;
    localparam int EPDR_B = 4;
    localparam int EXT_B  = 5;

    typedef enum logic [5:0] {
        LINK_FAILED = 6'b000001,
        IDLE        = 6'b000010,
        RECEIVE     = 6'b000100,
        EPD_T       = 6'b001000,
        EPD_R       = 6'b010000,
        CARRIER_EXT = 6'b100000
    } state_t;

    state_t     state, state_n;
    logic       errored, errored_n;
    logic       dv_n, er_n;
    logic [7:0] rxd_n;
    logic       ok_inc, err_inc;
    logic       in_pkt, in_pkt_n;

    // K matches only count for a valid code group
    logic kvalid, is_i, is_s, is_t, is_r, is_d;
    assign kvalid = rx_is_k && !rx_invalid;
    assign is_i   = kvalid && (rx_octet == K28_5);
    assign is_s   = kvalid && (rx_octet == K_S);
    assign is_t   = kvalid && (rx_octet == K_T);
    assign is_r   = kvalid && (rx_octet == K_R);
    assign is_d   = !rx_is_k && !rx_invalid;

    assign in_pkt   = state[RX_B] | state[EPDT_B] | state[EPDR_B];
    assign in_pkt_n = state_n[RX_B] | state_n[EPDT_B] | state_n[EPDR_B];

    always_comb begin
        state_n   = state;
        errored_n = errored;
        dv_n      = 1'b0;
        er_n      = 1'b0;
        rxd_n     = 8'h00;
        ok_inc    = 1'b0;
        err_inc   = 1'b0;
        if (!sync_status) begin
            state_n = LINK_FAILED;
            if (in_pkt) begin
                dv_n    = 1'b1;
                er_n    = 1'b1;
                err_inc = 1'b1;
            end
        end else begin
            unique case (1'b1)
                state[LF_B]: begin
                    if (is_i && rx_even) state_n = IDLE;
                end
                state[IDLE_B]: begin
                    if (is_s && rx_even) begin
                        state_n   = RECEIVE;
                        dv_n      = 1'b1;
                        rxd_n     = 8'h55;
                        errored_n = 1'b0;
                    end else if (!((is_i && rx_even) || (is_d && !rx_even))) begin
                        er_n  = 1'b1;
                        rxd_n = 8'h0E;
                    end
                end
                state[RX_B]: begin
                    if (is_d) begin
                        dv_n  = 1'b1;
                        rxd_n = rx_octet;
                    end else if (is_t) begin
                        state_n = EPD_T;
                    end else if (is_i) begin
                        state_n = IDLE;
                        dv_n    = 1'b1;
                        er_n    = 1'b1;
                        err_inc = 1'b1;
                    end else begin
                        dv_n      = 1'b1;
                        er_n      = 1'b1;
                        rxd_n     = rx_octet;
                        errored_n = 1'b1;
                    end
                end
                state[EPDT_B]: begin
                    if (is_r) begin
                        state_n = EPD_R;
                    end else begin
                        state_n = IDLE;
                        er_n    = 1'b1;
                        err_inc = 1'b1;
                    end
                end
                state[EPDR_B], state[EXT_B]: begin
                    if (is_i && rx_even) begin
                        state_n = IDLE;
                        ok_inc  = !errored;
                        err_inc = errored;
                    end else if (is_r) begin
                        state_n = CARRIER_EXT;
                        er_n    = 1'b1;
                        rxd_n   = 8'h0F;
                    end else begin
                        state_n = IDLE;
                        er_n    = 1'b1;
                        err_inc = 1'b1;
                    end
                end
                default: state_n = LINK_FAILED;
            endcase
        end
    end

    always_ff @(posedge gtx_clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state       <= LINK_FAILED;
            errored     <= 1'b0;
            rx_dv       <= 1'b0;
            rx_er       <= 1'b0;
            rxd         <= 8'h00;
            receiving   <= 1'b0;
            pkt_ok_cnt  <= '0;
            pkt_err_cnt <= '0;
        end else begin
            state     <= state_n;
            errored   <= errored_n;
            rx_dv     <= dv_n;
            rx_er     <= er_n;
            rxd       <= rxd_n;
            receiving <= in_pkt_n;
            if (ok_inc) pkt_ok_cnt <= pkt_ok_cnt + CNT_ONE;
            if (err_inc) pkt_err_cnt <= pkt_err_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_receive_ordered_set.sv
// tb_receive_ordered_set: table vectors, directed corner sequences and
// random code groups checked against a behavioural receive model.
module tb_receive_ordered_set;

    localparam int CW = 4;
    localparam int CMASK = (1 << CW) - 1;

    logic          gtx_clk = 1'b0;
    logic          mr_main_reset;
    logic          sync_status;
    logic          rx_even;
    logic [7:0]    rx_octet;
    logic          rx_is_k;
    logic          rx_invalid;
    logic          rx_dv;
    logic          rx_er;
    logic [7:0]    rxd;
    logic          receiving;
    logic [CW-1:0] pkt_ok_cnt;
    logic [CW-1:0] pkt_err_cnt;

    receive_ordered_set #(.CNT_WIDTH(CW)) dut (
        .gtx_clk      (gtx_clk),
        .mr_main_reset(mr_main_reset),
        .sync_status  (sync_status),
        .rx_even      (rx_even),
        .rx_octet     (rx_octet),
        .rx_is_k      (rx_is_k),
        .rx_invalid   (rx_invalid),
        .rx_dv        (rx_dv),
        .rx_er        (rx_er),
        .rxd          (rxd),
        .receiving    (receiving),
        .pkt_ok_cnt   (pkt_ok_cnt),
        .pkt_err_cnt  (pkt_err_cnt)
    );

    always #5 gtx_clk = ~gtx_clk;

    typedef struct packed {
        logic          dv;
        logic          er;
        logic [7:0]    rxd;
        logic          recv;
        logic [CW-1:0] ok;
        logic [CW-1:0] err;
    } obs_t;

    typedef struct {
        bit       ev;
        bit       k;
        bit       inv;
        bit [7:0] oct;
        obs_t     exp;
    } vec_t;

    int nvec = 0;
    int nbad = 0;
    bit par;

    // Behavioural model: where we are in a frame, plus counters
    localparam int P_DOWN = 0, P_IDLE = 1, P_PKT = 2;
    localparam int P_T = 3, P_R = 4, P_EXT = 5;
    localparam int G_I = 0, G_S = 1, G_T = 2, G_R = 3;
    localparam int G_K = 4, G_D = 5, G_BAD = 6;

    int       m_ph;
    bit       m_bad;
    int       m_ok, m_err;
    bit       m_dv, m_er;
    bit [7:0] m_rxd;

    function automatic int kind(bit k, bit inv, bit [7:0] o);
        if (inv) return G_BAD;
        if (!k) return G_D;
        case (o)
            8'hBC: return G_I;
            8'hFB: return G_S;
            8'hFD: return G_T;
            8'hF7: return G_R;
            default: return G_K;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = P_DOWN; m_bad = 0; m_ok = 0; m_err = 0;
        m_dv = 0; m_er = 0; m_rxd = 8'h00;
    endtask

    task automatic bump(bit good);
        if (good) m_ok = (m_ok + 1) & CMASK;
        else m_err = (m_err + 1) & CMASK;
    endtask

    task automatic model_step(bit s, bit ev, bit k, bit inv, bit [7:0] o);
        int g;
        g = kind(k, inv, o);
        m_dv = 0; m_er = 0; m_rxd = 8'h00;
        if (!s) begin
            if (m_ph == P_PKT || m_ph == P_T || m_ph == P_R) begin
                m_dv = 1; m_er = 1; bump(0);
            end
            m_ph = P_DOWN;
        end else begin
            case (m_ph)
                P_DOWN: if (g == G_I && ev) m_ph = P_IDLE;
                P_IDLE: begin
                    if (g == G_S && ev) begin
                        m_dv = 1; m_rxd = 8'h55; m_ph = P_PKT; m_bad = 0;
                    end else if (!((g == G_I && ev) || (g == G_D && !ev))) begin
                        m_er = 1; m_rxd = 8'h0E;
                    end
                end
                P_PKT: begin
                    if (g == G_D) begin
                        m_dv = 1; m_rxd = o;
                    end else if (g == G_T) begin
                        m_ph = P_T;
                    end else if (g == G_I) begin
                        m_dv = 1; m_er = 1; m_ph = P_IDLE; bump(0);
                    end else begin
                        m_dv = 1; m_er = 1; m_rxd = o; m_bad = 1;
                    end
                end
                P_T: begin
                    if (g == G_R) m_ph = P_R;
                    else begin
                        m_er = 1; m_ph = P_IDLE; bump(0);
                    end
                end
                default: begin
                    if (g == G_I && ev) begin
                        m_ph = P_IDLE; bump(!m_bad);
                    end else if (g == G_R) begin
                        m_er = 1; m_rxd = 8'h0F; m_ph = P_EXT;
                    end else begin
                        m_er = 1; m_ph = P_IDLE; bump(0);
                    end
                end
            endcase
        end
    endtask

    function automatic obs_t model_obs();
        obs_t r;
        r.dv   = m_dv;
        r.er   = m_er;
        r.rxd  = m_rxd;
        r.recv = (m_ph == P_PKT || m_ph == P_T || m_ph == P_R);
        r.ok   = CW'(m_ok);
        r.err  = CW'(m_err);
        return r;
    endfunction

    task automatic check(input string nm, input obs_t exp);
        obs_t got;
        got = {rx_dv, rx_er, rxd, receiving, pkt_ok_cnt, pkt_err_cnt};
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s t=%0t got dv=%b er=%b rxd=%h recv=%b ok=%0d err=%0d want dv=%b er=%b rxd=%h recv=%b ok=%0d err=%0d",
                     nm, $time, got.dv, got.er, got.rxd, got.recv, got.ok, got.err,
                     exp.dv, exp.er, exp.rxd, exp.recv, exp.ok, exp.err);
        end
    endtask

    task automatic drive(bit s, bit ev, bit k, bit inv, bit [7:0] o);
        sync_status = s; rx_even = ev; rx_is_k = k;
        rx_invalid = inv; rx_octet = o;
        model_step(s, ev, k, inv, o);
        @(posedge gtx_clk);
        #1;
    endtask

    task automatic send(bit s, bit k, bit inv, bit [7:0] o);
        drive(s, par, k, inv, o);
        par = ~par;
    endtask

    task automatic send_chk(string nm, bit s, bit k, bit inv, bit [7:0] o);
        send(s, k, inv, o);
        check(nm, model_obs());
    endtask

    task automatic good_pkt();
        if (!par) send_chk("pad", 1, 0, 0, 8'hC5);
        send_chk("pkt_s", 1, 1, 0, 8'hFB);
        for (int i = 0; i < 3; i++)
            send_chk("pkt_d", 1, 0, 0, 8'($urandom_range(255)));
        send_chk("pkt_t", 1, 1, 0, 8'hFD);
        send_chk("pkt_r", 1, 1, 0, 8'hF7);
        send_chk("pkt_i", 1, 1, 0, 8'hBC);
        send_chk("pkt_c5", 1, 0, 0, 8'hC5);
    endtask

    function automatic vec_t v(bit ev, bit k, bit inv, bit [7:0] o, bit dv,
                               bit er, bit [7:0] rd, bit rc, int ok, int err);
        vec_t r;
        r.ev = ev; r.k = k; r.inv = inv; r.oct = o;
        r.exp = '{dv: dv, er: er, rxd: rd, recv: rc, ok: CW'(ok), err: CW'(err)};
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        obs_t e;
        int   pick;
        bit   s, k, inv;
        bit [7:0] o;

        mr_main_reset = 1; sync_status = 0; rx_even = 0;
        rx_octet = 8'h00; rx_is_k = 0; rx_invalid = 0;
        model_reset();
        repeat (2) @(posedge gtx_clk);
        #1;
        check("reset", '0);
        mr_main_reset = 0;

        // link up on idles
        tbl.push_back(v(1, 1, 0, 8'hBC, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 8'hC5, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(1, 1, 0, 8'hBC, 0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 8'hC5, 0, 0, 8'h00, 0, 0, 0));
        // normal packet
        tbl.push_back(v(1, 1, 0, 8'hFB, 1, 0, 8'h55, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 8'h11, 1, 0, 8'h11, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 8'h22, 1, 0, 8'h22, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, 8'h33, 1, 0, 8'h33, 1, 0, 0));
        tbl.push_back(v(1, 1, 0, 8'hFD, 0, 0, 8'h00, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 8'hF7, 0, 0, 8'h00, 1, 0, 0));
        tbl.push_back(v(1, 1, 0, 8'hBC, 0, 0, 8'h00, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 8'hC5, 0, 0, 8'h00, 0, 1, 0));
        // carrier extension
        tbl.push_back(v(1, 1, 0, 8'hFB, 1, 0, 8'h55, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 8'h11, 1, 0, 8'h11, 1, 1, 0));
        tbl.push_back(v(1, 1, 0, 8'hFD, 0, 0, 8'h00, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 8'hF7, 0, 0, 8'h00, 1, 1, 0));
        tbl.push_back(v(1, 1, 0, 8'hF7, 0, 1, 8'h0F, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 8'hF7, 0, 1, 8'h0F, 0, 1, 0));
        tbl.push_back(v(1, 1, 0, 8'hBC, 0, 0, 8'h00, 0, 2, 0));
        tbl.push_back(v(0, 0, 0, 8'hC5, 0, 0, 8'h00, 0, 2, 0));
        // invalid data byte inside a packet
        tbl.push_back(v(1, 1, 0, 8'hFB, 1, 0, 8'h55, 1, 2, 0));
        tbl.push_back(v(0, 0, 1, 8'h11, 1, 1, 8'h11, 1, 2, 0));
        tbl.push_back(v(1, 0, 0, 8'h22, 1, 0, 8'h22, 1, 2, 0));
        tbl.push_back(v(0, 0, 0, 8'h33, 1, 0, 8'h33, 1, 2, 0));
        tbl.push_back(v(1, 1, 0, 8'hFD, 0, 0, 8'h00, 1, 2, 0));
        tbl.push_back(v(0, 1, 0, 8'hF7, 0, 0, 8'h00, 1, 2, 0));
        tbl.push_back(v(1, 1, 0, 8'hBC, 0, 0, 8'h00, 0, 2, 1));
        tbl.push_back(v(0, 0, 0, 8'hC5, 0, 0, 8'h00, 0, 2, 1));
        // false carrier
        tbl.push_back(v(1, 1, 0, 8'hBC, 0, 0, 8'h00, 0, 2, 1));
        tbl.push_back(v(0, 1, 0, 8'hFB, 0, 1, 8'h0E, 0, 2, 1));
        tbl.push_back(v(1, 0, 0, 8'h44, 0, 1, 8'h0E, 0, 2, 1));
        tbl.push_back(v(0, 0, 0, 8'hC5, 0, 0, 8'h00, 0, 2, 1));
        tbl.push_back(v(1, 1, 0, 8'hBC, 0, 0, 8'h00, 0, 2, 1));

        foreach (tbl[i]) begin
            drive(1, tbl[i].ev, tbl[i].k, tbl[i].inv, tbl[i].oct);
            check($sformatf("table[%0d]", i), tbl[i].exp);
            par = ~tbl[i].ev;
        end

        // sync loss mid-packet
        send_chk("sd_c5", 1, 0, 0, 8'hC5);
        send_chk("sd_s", 1, 1, 0, 8'hFB);
        send_chk("sd_d", 1, 0, 0, 8'h11);
        send(0, 0, 0, 8'h22);
        check("sync_drop", model_obs());
        check("sync_drop_fixed",
              '{dv: 1'b1, er: 1'b1, rxd: 8'h00, recv: 1'b0, ok: CW'(2), err: CW'(2)});
        send_chk("sync_low", 0, 0, 0, 8'hC5);
        send_chk("relink_i", 1, 1, 0, 8'hBC);
        send_chk("relink_c5", 1, 0, 0, 8'hC5);

        // good-packet counter wrap
        for (int n = 0; n < 20 && m_ok != CMASK; n++) good_pkt();
        check("ok_at_max",
              '{dv: 1'b0, er: 1'b0, rxd: 8'h00, recv: 1'b0, ok: CW'(CMASK), err: CW'(2)});
        good_pkt();
        check("ok_wrap",
              '{dv: 1'b0, er: 1'b0, rxd: 8'h00, recv: 1'b0, ok: CW'(0), err: CW'(2)});

        // asynchronous reset in the middle of a packet
        if (!par) send_chk("pad", 1, 0, 0, 8'hC5);
        send_chk("rst_s", 1, 1, 0, 8'hFB);
        send_chk("rst_d", 1, 0, 0, 8'h5A);
        mr_main_reset = 1;
        #2;
        check("async_reset", '0);
        model_reset();
        @(posedge gtx_clk);
        #1;
        check("reset_hold", '0);
        mr_main_reset = 0;

        // random code groups
        par = 1;
        for (int c = 0; c < 3000; c++) begin
            s = ($urandom_range(99) >= 3);
            inv = 0;
            pick = $urandom_range(99);
            if (pick < 30) begin
                k = 0; o = 8'($urandom_range(255));
            end else if (pick < 50) begin
                k = 1; o = 8'hBC;
            end else if (pick < 60) begin
                k = 1; o = 8'hFB;
            end else if (pick < 72) begin
                k = 1; o = 8'hFD;
            end else if (pick < 90) begin
                k = 1; o = 8'hF7;
            end else if (pick < 94) begin
                k = 1; o = 8'hFE;
            end else if (pick < 97) begin
                k = 1; o = 8'($urandom_range(255));
            end else begin
                k = 1'($urandom_range(1)); o = 8'($urandom_range(255)); inv = 1;
            end
            if ($urandom_range(99) < 2) par = ~par;
            send_chk("random", s, k, inv, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
